paramest_dense_acc: RTL

PARAMEST_DENSE_ACC -- requirements
Module: paramest_dense_acc

---
 rtl/paramest_dense_acc_if.sv | 21 ++
 rtl/paramest_dense_acc.sv | 68 ++++++
 2 files changed

// File: rtl/paramest_dense_acc_if.sv
// paramest_dense_acc_if: input/output handshake bundle for the dense-layer accumulator
interface paramest_dense_acc_if #(
    parameter int OUT_W = 16
);
    logic signed [28:0]      in_data;
    logic signed [OUT_W-1:0] in_bias;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [5:0]              beat_cnt;
    modport master (
        output in_data, in_bias, in_valid, out_ready,
        input  in_ready, out_data, out_valid, beat_cnt
    );
    modport slave (
        input  in_data, in_bias, in_valid, out_ready,
        output in_ready, out_data, out_valid, beat_cnt
    );
endinterface

// File: rtl/paramest_dense_acc.sv
// paramest_dense_acc: neuron accumulator (bias, round half up, saturate); PARAMEST_DENSE_ACC_RELU_EN fuses ReLU
module paramest_dense_acc #(
    parameter int N_IN       = 5,
    parameter int ACC_W      = 36,
    parameter int FRAC_SHIFT = 12,
    parameter int OUT_W      = 16
) (
    input logic                 ap_clk,
    input logic                 ap_rst_n,
    paramest_dense_acc_if.slave bus
);
    typedef enum logic [1:0] {ACCUM, ROUND, HOLD} state_t;
    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
    state_t                  state, nxt;
    logic                    run;
    logic signed [ACC_W-1:0] acc, din_x, bias_x, sum, rnd, sat;
    logic signed [OUT_W-1:0] out_q, res;
    logic [5:0]              beat_cnt;
    logic                    accept, last;
    assign din_x        = ACC_W'(bus.in_data);
    assign bias_x       = ACC_W'(bus.in_bias) <<< FRAC_SHIFT;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last         = beat_cnt == 6'(N_IN - 1);
    assign bus.in_ready = run && state == ACCUM;
    assign bus.out_valid = state == HOLD;
    assign bus.out_data = out_q;
    assign bus.beat_cnt = beat_cnt;
    // next state plus the rounded, saturated result of the current sum
    always_comb begin
        sum = acc + HALF;
        rnd = sum >>> FRAC_SHIFT;
        sat = rnd > MAX_V ? MAX_V : rnd < MIN_V ? MIN_V : rnd;
`ifdef PARAMEST_DENSE_ACC_RELU_EN
        res = sat[ACC_W-1] ? '0 : sat[OUT_W-1:0];
`else
        res = sat[OUT_W-1:0];
`endif
        nxt = (state == ACCUM && accept && last) ? ROUND :
              (state == ROUND) ? HOLD :
              (state == HOLD && bus.out_ready) ? ACCUM : state;
    end
    // state register; run holds in_ready low until the first edge after reset release
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ACCUM;
            run   <= 1'b0;
        end else begin
            state <= nxt;
            run   <= 1'b1;
        end
    end
    // accumulator, beat counter and output register; the first beat of a group reloads with the bias
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
            out_q    <= '0;
        end else begin
            if (accept) begin
                acc      <= (beat_cnt == 6'd0 ? bias_x : acc) + din_x;
                beat_cnt <= last ? 6'd0 : beat_cnt + 6'd1;
            end
            if (state == ROUND) out_q <= res;
        end
    end
endmodule
